// File: rtl/led_sequencer.sv
// Two-byte UART command parser driving five LEDs (set/clear/toggle/blink),
// with a single-entry response slot toward the transmitter and a sticky drop flag.

module led_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_exec,
  input  logic       i_sel,
  input  logic [1:0] i_op,
  input  logic       i_phase_nxt,
  output logic       o_led
);
  localparam logic [1:0] OP_S = 2'd0;
  localparam logic [1:0] OP_C = 2'd1;
  localparam logic [1:0] OP_T = 2'd2;
  localparam logic [1:0] OP_B = 2'd3;

  logic r_state, r_blink, r_led;
  logic w_state_nxt, w_blink_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    if (i_exec && i_sel) begin
      case (i_op)
        OP_S: begin w_state_nxt = 1'b1;     w_blink_nxt = 1'b0; end
        OP_C: begin w_state_nxt = 1'b0;     w_blink_nxt = 1'b0; end
        OP_T: begin w_state_nxt = ~r_state; w_blink_nxt = 1'b0; end
        OP_B: begin                         w_blink_nxt = 1'b1; end
      endcase
    end
  end

  // LED register is fed from next-state values so a command shows one cycle after its arg byte
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= 1'b0;
      r_blink <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blink <= w_blink_nxt;
      r_led   <= w_blink_nxt ? i_phase_nxt : w_state_nxt;
    end
  end

  assign o_led = r_led;
endmodule

module led_sequencer #(
  parameter int BLINK_DIV = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ready,
  output logic [0:4] leds,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       drop
);
  localparam int          NUM_LEDS = 5;
  localparam logic [23:0] CNT_MAX  = 24'(BLINK_DIV - 1);
  localparam logic [7:0]  RESP_K   = 8'h4B;
  localparam logic [7:0]  RESP_E   = 8'h45;

  typedef enum logic {S_IDLE, S_ARG} fsm_t;

  fsm_t        r_fsm, w_fsm_nxt;
  logic [1:0]  r_op, w_op_nxt;
  logic [23:0] r_cnt;
  logic        r_phase;
  logic        w_cnt_wrap, w_phase_nxt;
  logic        w_is_op, w_is_ws, w_is_arg;
  logic [1:0]  w_op_code;
  logic [0:4]  w_sel;
  logic        w_exec, w_resp;
  logic [7:0]  w_resp_byte;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid, r_drop;

  always_comb begin
    w_is_op   = 1'b1;
    w_op_code = 2'd0;
    case (data)
      8'h53:   w_op_code = 2'd0;
      8'h43:   w_op_code = 2'd1;
      8'h54:   w_op_code = 2'd2;
      8'h42:   w_op_code = 2'd3;
      default: w_is_op   = 1'b0;
    endcase
    w_is_ws  = (data == 8'h0D) || (data == 8'h0A) || (data == 8'h20);
    w_is_arg = (data >= 8'h30) && (data <= 8'h35);
    for (int i = 0; i < NUM_LEDS; i++)
      w_sel[i] = (data == 8'h30) || (data == 8'(8'h31 + i));
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_op_nxt    = r_op;
    w_exec      = 1'b0;
    w_resp      = 1'b0;
    w_resp_byte = RESP_K;
    if (ready) begin
      case (r_fsm)
        S_IDLE: begin
          if (w_is_op) begin
            w_fsm_nxt = S_ARG;
            w_op_nxt  = w_op_code;
          end else if (!w_is_ws) begin
            w_resp      = 1'b1;
            w_resp_byte = RESP_E;
          end
        end
        S_ARG: begin
          w_fsm_nxt = S_IDLE;
          w_resp    = 1'b1;
          if (w_is_arg) w_exec = 1'b1;
          else          w_resp_byte = RESP_E;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fsm <= S_IDLE;
      r_op  <= 2'd0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_op  <= w_op_nxt;
    end
  end

  assign w_cnt_wrap  = (r_cnt == CNT_MAX);
  assign w_phase_nxt = r_phase ^ w_cnt_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= 24'd0;
      r_phase <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_wrap ? 24'd0 : r_cnt + 24'd1;
      r_phase <= w_phase_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_lane
    led_lane u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_exec     (w_exec),
      .i_sel      (w_sel[gi]),
      .i_op       (r_op),
      .i_phase_nxt(w_phase_nxt),
      .o_led      (leds[gi])
    );
  end

  // Single response slot: a handshake frees it in the same cycle a new response may load
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_drop     <= 1'b0;
    end else if (r_tx_valid && !tx_ready) begin
      if (w_resp) r_drop <= 1'b1;
    end else if (w_resp) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_resp_byte;
    end else begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign drop     = r_drop;
endmodule

// File: tb/tb_led_sequencer.sv
// Randomized + directed bench for led_sequencer against a command-level reference model.

module tb_led_sequencer;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic [0:4] leds;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       drop;

  led_sequencer #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .data(data), .ready(ready), .leds(leds),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .drop(drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending op byte (0 = none), per-LED state/blink, elapsed cycles since reset
  int         n = 0;
  byte        pend = 0;
  bit         mst[5];
  bit         mbl[5];
  bit         mtv = 0, mdrop = 0, mvalid = 0;
  logic [7:0] mtd = 8'h00;

  always @(posedge clk) begin
    bit         resp;
    logic [7:0] rb;
    if (!reset) begin
      n = 0; pend = 0; mtv = 0; mdrop = 0; mtd = 8'h00; mvalid = 1;
      for (int i = 0; i < 5; i++) begin mst[i] = 0; mbl[i] = 0; end
    end else begin
      n++;
      resp = 0; rb = 8'h00;
      if (ready) begin
        if (pend == 0) begin
          if (data == "S" || data == "C" || data == "T" || data == "B") pend = data;
          else if (!(data == 8'h0D || data == 8'h0A || data == 8'h20)) begin resp = 1; rb = "E"; end
        end else begin
          if (data >= "0" && data <= "5") begin
            for (int i = 0; i < 5; i++) begin
              if (data == "0" || int'(data) - int'("1") == i) begin
                case (pend)
                  "S": begin mst[i] = 1; mbl[i] = 0; end
                  "C": begin mst[i] = 0; mbl[i] = 0; end
                  "T": begin mst[i] = !mst[i]; mbl[i] = 0; end
                  default: mbl[i] = 1;
                endcase
              end
            end
            rb = "K";
          end else rb = "E";
          resp = 1; pend = 0;
        end
      end
      if (mtv && !tx_ready) begin
        if (resp) mdrop = 1;
      end else if (resp) begin
        mtv = 1; mtd = rb;
      end else mtv = 0;
    end
  end

  always @(negedge clk) begin
    logic [0:4] exp;
    bit ph;
    if (mvalid) begin
      ph = ((n / DIV) % 2) == 1;
      for (int i = 0; i < 5; i++) exp[i] = mbl[i] ? ph : mst[i];
      chk("model_leds", 32'(leds), 32'(exp));
      chk("model_tx_valid", 32'(tx_valid), 32'(mtv));
      chk("model_tx_data", 32'(tx_data), 32'(mtd));
      chk("model_drop", 32'(drop), 32'(mdrop));
    end
  end

  logic [7:0] hs_q[$];
  always @(negedge clk)
    if (reset && tx_valid && tx_ready) hs_q.push_back(tx_data);

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data = b; ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic do_reset(input int k);
    reset = 1'b0;
    tick(k);
    reset = 1'b1;
    hs_q.delete();
  endtask

  logic [7:0] tbl [16] = '{8'h53, 8'h43, 8'h54, 8'h42, 8'h30, 8'h31, 8'h32, 8'h33,
                           8'h34, 8'h35, 8'h58, 8'h39, 8'h0D, 8'h0A, 8'h20, 8'h61};

  initial begin
    int tog;
    logic prev;
    #1;
    do_reset(3);
    chk("reset_leds", 32'(leds), 32'(5'b00000));
    chk("reset_tx_valid", 32'(tx_valid), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_drop", 32'(drop), 0);

    send("S"); send("3");
    chk("s3_leds", 32'(leds), 32'(5'b00100));
    chk("s3_tx_data", 32'(tx_data), 32'h4B);
    tick(3);
    chk("s3_hs_count", hs_q.size(), 1);
    chk("s3_hs_byte", 32'(hs_q[0]), 32'h4B);

    do_reset(1);
    send("S"); send("0");
    chk("s0_leds", 32'(leds), 32'(5'b11111));
    send("T"); send("2");
    chk("t2_leds", 32'(leds), 32'(5'b10111));
    tick(3);
    chk("s0t2_hs_count", hs_q.size(), 2);
    chk("s0t2_hs_byte", 32'(hs_q[1]), 32'h4B);

    hs_q.delete();
    send("X"); send("S"); send("9");
    tick(3);
    chk("err_leds", 32'(leds), 32'(5'b10111));
    chk("err_hs_count", hs_q.size(), 2);
    chk("err_hs_0", 32'(hs_q[0]), 32'h45);
    chk("err_hs_1", 32'(hs_q[1]), 32'h45);
    hs_q.delete();
    send(8'h0D); send(8'h0A); send(8'h20);
    tick(3);
    chk("ws_hs_count", hs_q.size(), 0);
    send("C"); send("0");
    chk("c0_leds", 32'(leds), 32'(5'b00000));

    send("B"); send("5");
    tog = 0; prev = leds[4];
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (leds[4] != prev) tog++;
      prev = leds[4];
    end
    chk("blink_toggles", tog, 3);
    chk("blink_others", 32'(leds[0:3]), 0);
    send("C"); send("5");
    tog = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (leds[4]) tog++;
    end
    chk("c5_steady_low", tog, 0);

    do_reset(1);
    tx_ready = 1'b0;
    send("S"); send("1"); send("S"); send("2");
    chk("drop_leds", 32'(leds), 32'(5'b11000));
    chk("drop_tx_data", 32'(tx_data), 32'h4B);
    chk("drop_tx_valid", 32'(tx_valid), 1);
    chk("drop_flag", 32'(drop), 1);
    tx_ready = 1'b1;
    tick(1);
    chk("drop_tx_valid_after", 32'(tx_valid), 0);
    tick(2);
    chk("drop_hs_count", hs_q.size(), 1);
    chk("drop_sticky", 32'(drop), 1);

    do_reset(1);
    send("T");
    do_reset(1);
    send("S"); send("4");
    tick(3);
    chk("abandon_leds", 32'(leds), 32'(5'b00010));
    chk("abandon_hs_count", hs_q.size(), 1);
    chk("abandon_hs_byte", 32'(hs_q[0]), 32'h4B);
    chk("abandon_drop", 32'(drop), 0);

    for (int c = 0; c < 4000; c++) begin
      ready    = ($urandom_range(0, 99) < 60);
      data     = tbl[$urandom_range(0, 15)];
      tx_ready = ($urandom_range(0, 99) < (((c / 500) % 2) == 1 ? 90 : 30));
      reset    = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    reset = 1'b1; ready = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
